cc_reg: RTL

Condition-code register stage for the Y86-64 single-cycle core. Derives ZF/SF/OF from the current ALU operation (`addq`/`subq`/`andq`/`xorq`) and latches them on the clock edge when an OPq instruction sets condition codes. The latched flags feed the condition evaluator that produces `Cnd` for `jXX`/`cmovXX`. Flag updates freeze permanently once the processor enters a non-AOK status, until reset.

---
 rtl/cc_reg.sv | 47 ++++
 1 files changed

// File: rtl/cc_reg.sv
// cc_reg: Y86-64 condition-code register that freezes on the first non-AOK status
module cc_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   alufun,
  input  logic [W-1:0] aluA,
  input  logic [W-1:0] aluB,
  input  logic [W-1:0] valE,
  input  logic         set_cc,
  input  logic         stall,
  input  logic         stat_err,
  output logic         ZF,
  output logic         SF,
  output logic         OF,
  output logic         frozen
);
  typedef enum logic {RUN, FRZ} state_t;
  state_t state;
  logic zf_n, sf_n, of_n, we;
  always_comb begin
    zf_n = valE == '0;
    sf_n = valE[W-1];
    of_n = alufun == 4'd0 ? (aluA[W-1] == aluB[W-1]) && (valE[W-1] != aluA[W-1]) :
           alufun == 4'd1 ? (aluA[W-1] != aluB[W-1]) && (valE[W-1] != aluB[W-1]) : 1'b0;
    we   = set_cc && !stall && !stat_err && alufun <= 4'd3;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      ZF     <= 1'b1;
      SF     <= 1'b0;
      OF     <= 1'b0;
      frozen <= 1'b0;
    end else if (state == RUN) begin
      if (stat_err) begin
        state  <= FRZ;
        frozen <= 1'b1;
      end else if (we) begin
        ZF <= zf_n;
        SF <= sf_n;
        OF <= of_n;
      end
    end
  end
endmodule
